// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared types and helpers for the UART command-frame sequencer.
//   - state_t      : frame-assembly FSM states
//   - HDR_DEFAULT  : default frame header byte
//   - ERR_CNT_MAX  : saturation value of the framing-error counter
//   - chk8()       : frame checksum, ~(hi + lo) mod 256
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    CHK  = 2'd3
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic [7:0] chk8(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] sum;
    sum = hi + lo;  // 8-bit wrap is intended
    return ~sum;
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_ibyte_timer.sv
// ibyte_timer
//   Inter-byte timeout counter. Counts while en=1, restarts on clr or when
//   disabled, and raises expired for exactly one cycle once the count reaches
//   TIMEOUT_CYC without a clr in that same cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count (a byte was accepted)
//   en        : count enable (a frame is in progress)
//   expired   : one-cycle timeout pulse
module ibyte_timer #(
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int unsigned TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here is given a value on every path (defaults
  // first), so no latches are inferred.
  always_comb begin
    expired = en && !clr && (cnt_q == TW'(TIMEOUT_CYC));
    cnt_d   = cnt_q + TW'(1);
    // Restarting on expiry keeps expired a single-cycle pulse even if en lingers.
    if (clr || !en || expired) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Sequences a uart_rcv: accepts each byte once on the rising edge of rx_rdy,
//   acknowledges it, and assembles HDR/hi/lo/checksum frames into a 16-bit
//   command. Checksum failures and inter-byte timeouts pulse frm_err and are
//   counted in a saturating err_cnt.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rx_rdy        : byte ready from uart_rcv
//   rx_data[7:0]  : received byte, valid while rx_rdy=1
//   clr_rx_rdy    : registered one-cycle acknowledge to uart_rcv
//   cmd[15:0]     : last valid command {hi,lo}
//   cmd_rdy       : valid command pending
//   clr_cmd_rdy   : consumer acknowledge, clears cmd_rdy
//   frm_err       : one-cycle pulse on checksum failure or timeout
//   overrun       : sticky, a command landed while cmd_rdy was still set
//   err_cnt[7:0]  : saturating framing-error count
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HDR         = HDR_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int unsigned TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frm_err,
  output logic        overrun,
  output logic [7:0]  err_cnt
);

  state_t      state_q, state_d;
  logic        rx_rdy_q;
  logic        clr_rx_rdy_q;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        frm_err_q, frm_err_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic acc;        // byte accepted this cycle
  logic valid;      // checksum byte matched this cycle
  logic expired;

  assign acc = rx_rdy && !rx_rdy_q;

  ibyte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TW          (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc),
    .en      (state_q != HUNT),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cmd_d     = cmd_q;
    frm_err_d = 1'b0;
    valid     = 1'b0;

    // expired is already masked by acc, so an arriving byte always wins.
    unique case (state_q)
      HUNT: if (acc && rx_data == HDR) state_d = HI;
      HI: begin
        if (acc) begin
          hi_d    = rx_data;
          state_d = LO;
        end else if (expired) begin
          frm_err_d = 1'b1;
          state_d   = HUNT;
        end
      end
      LO: begin
        if (acc) begin
          lo_d    = rx_data;
          state_d = CHK;
        end else if (expired) begin
          frm_err_d = 1'b1;
          state_d   = HUNT;
        end
      end
      CHK: begin
        if (acc) begin
          state_d = HUNT;
          if (rx_data == chk8(hi_q, lo_q)) begin
            valid = 1'b1;
            cmd_d = {hi_q, lo_q};
          end else begin
            frm_err_d = 1'b1;
          end
        end else if (expired) begin
          frm_err_d = 1'b1;
          state_d   = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    // Set beats clear when a frame lands in the same cycle as the ack.
    cmd_rdy_d = valid ? 1'b1 : (clr_cmd_rdy ? 1'b0 : cmd_rdy_q);

    // An ack racing a landing frame refers to the older command, so it does
    // not clear an overrun flag already standing.
    if (valid && cmd_rdy_q && !clr_cmd_rdy) overrun_d = 1'b1;
    else if (clr_cmd_rdy && !valid)         overrun_d = 1'b0;
    else                                    overrun_d = overrun_q;

    err_cnt_d = err_cnt_q;
    if (frm_err_d && err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      rx_rdy_q     <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rx_rdy_q     <= rx_rdy;
      clr_rx_rdy_q <= acc;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      frm_err_q    <= frm_err_d;
      overrun_q    <= overrun_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frm_err    = frm_err_q;
  assign overrun    = overrun_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
//   Directed bench for uart_cmd_sequencer with a short timeout (1000 clks).
//   Bytes are driven on the falling edge; outputs are sampled just after it.
module tb_uart_cmd_sequencer;

  localparam int unsigned TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frm_err;
  logic        overrun;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int ack_pulses = 0;
  int err_pulses = 0;

  uart_cmd_sequencer #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frm_err     (frm_err),
    .overrun     (overrun),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Cycles high at each falling edge; single-cycle pulses count once each.
  always @(negedge clk) begin
    if (clr_rx_rdy) ack_pulses++;
    if (frm_err)    err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge; rx_rdy high for 'hold' clks.
  task automatic send_byte(input logic [7:0] d, input int hold = 1, input logic ack = 1'b0);
    rx_rdy      = 1'b1;
    rx_data     = d;
    clr_cmd_rdy = ack;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    repeat (hold - 1) @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c);
    send_byte(h);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cmd"},        32'(cmd), 32'h0);
    check({tag, " cmd_rdy"},    32'(cmd_rdy), 32'h0);
    check({tag, " frm_err"},    32'(frm_err), 32'h0);
    check({tag, " overrun"},    32'(overrun), 32'h0);
    check({tag, " err_cnt"},    32'(err_cnt), 32'h0);
    check({tag, " clr_rx_rdy"}, 32'(clr_rx_rdy), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ack;
    int base_err;
    int waited;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    // Valid frame A5 12 34 B9
    base_ack = ack_pulses;
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    check("valid pre-chk cmd_rdy", 32'(cmd_rdy), 32'h0);
    send_byte(8'hB9);
    check("valid cmd",         32'(cmd), 32'h1234);
    check("valid cmd_rdy",     32'(cmd_rdy), 32'h1);
    check("valid ack pulses",  32'(ack_pulses - base_ack), 32'd4);
    check("valid err_cnt",     32'(err_cnt), 32'h0);
    check("valid overrun",     32'(overrun), 32'h0);
    ack_cmd();
    check("ack cmd_rdy",       32'(cmd_rdy), 32'h0);

    // Bad checksum A5 12 34 B8
    base_err = err_pulses;
    send_frame(8'hA5, 8'h12, 8'h34, 8'hB8);
    @(negedge clk); #1;
    check("badchk frm_err pulses", 32'(err_pulses - base_err), 32'd1);
    check("badchk err_cnt",        32'(err_cnt), 32'd1);
    check("badchk cmd_rdy",        32'(cmd_rdy), 32'h0);
    check("badchk cmd",            32'(cmd), 32'h1234);

    // Hunt, held rx_rdy, header as data: 00 FF(held 5) A5 A5 A5 B5
    base_ack = ack_pulses;
    send_byte(8'h00);
    send_byte(8'hFF, 5);
    check("hold accepted once", 32'(ack_pulses - base_ack), 32'd2);
    send_frame(8'hA5, 8'hA5, 8'hA5, 8'hB5);
    check("hdrdata cmd",     32'(cmd), 32'hA5A5);
    check("hdrdata cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("hdrdata err_cnt", 32'(err_cnt), 32'd1);
    ack_cmd();

    // Timeout: A5 12 then silence
    base_err = err_pulses;
    send_byte(8'hA5);
    send_byte(8'h12);
    waited = 0;
    for (int i = 1; i <= TO + 100; i++) begin
      @(negedge clk); #1;
      if (frm_err) begin
        waited = i;
        break;
      end
    end
    check("timeout seen",      32'(waited != 0), 32'h1);
    check("timeout in window", 32'(waited >= 999 && waited <= 1003), 32'h1);
    @(negedge clk); #1;
    check("timeout pulses",    32'(err_pulses - base_err), 32'd1);
    check("timeout err_cnt",   32'(err_cnt), 32'd2);
    send_frame(8'hA5, 8'h00, 8'h01, 8'hFE);
    check("post-timeout cmd",     32'(cmd), 32'h0001);
    check("post-timeout cmd_rdy", 32'(cmd_rdy), 32'h1);
    ack_cmd();

    // Overrun and ack race
    send_frame(8'hA5, 8'h11, 8'h11, 8'hDD);
    check("ovr f1 overrun", 32'(overrun), 32'h0);
    send_frame(8'hA5, 8'h22, 8'h22, 8'hBB);
    check("ovr f2 overrun", 32'(overrun), 32'h1);
    check("ovr f2 cmd",     32'(cmd), 32'h2222);
    send_byte(8'hA5);
    send_byte(8'h33);
    send_byte(8'h33);
    send_byte(8'h99, 1, 1'b1);
    check("race cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("race overrun", 32'(overrun), 32'h1);
    check("race cmd",     32'(cmd), 32'h3333);
    ack_cmd();
    check("lone ack cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("lone ack overrun", 32'(overrun), 32'h0);

    // Reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    send_frame(8'hA5, 8'h12, 8'h34, 8'hB9);
    check("post-rst cmd",     32'(cmd), 32'h1234);
    check("post-rst cmd_rdy", 32'(cmd_rdy), 32'h1);
    ack_cmd();

    // Saturation
    base_err = err_pulses;
    for (int f = 0; f < 300; f++) begin
      send_frame(8'hA5, 8'h12, 8'h34, 8'hB8);
      if (f == 253) begin
        @(negedge clk); #1;
        check("sat err_cnt at 254", 32'(err_cnt), 32'd254);
      end
    end
    @(negedge clk); #1;
    check("sat err_cnt",  32'(err_cnt), 32'd255);
    check("sat pulses",   32'(err_pulses - base_err), 32'd300);
    check("sat cmd_rdy",  32'(cmd_rdy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Frame-level controller that sits directly behind `uart_rcv` and sequences it: it detects each received byte, acknowledges it with `clr_rx_rdy`, and assembles a fixed 4-byte command frame (header, command high, command low, checksum) into a 16-bit command word for the command-processing logic. It enforces an inter-byte timeout and checksum validation, and counts framing errors. It is the only consumer of the receiver's `rx_rdy`/`rx_data` handshake.

## Interface
- `HDR`, default `8'hA5`: frame header byte.
- `TIMEOUT_CYC`, default `2_500_000`: max clocks between bytes inside a frame (50 ms at 50 MHz).
- `TW`, default `$clog2(TIMEOUT_CYC+1)`: timeout counter width.
- `clk`  in  1  system clock; one clock domain for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_rdy`  in  1  byte-ready from `uart_rcv`.
- `rx_data`  in  8  received byte; valid while `rx_rdy`=1.
- `clr_rx_rdy`  out  1  one-cycle acknowledge to `uart_rcv`.
- `cmd`  out  16  last valid command, `{hi,lo}`.
- `cmd_rdy`  out  1  valid command pending.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `frm_err`  out  1  one-cycle pulse on checksum failure or timeout.
- `overrun`  out  1  sticky: new command landed while `cmd_rdy` was still set.
- `err_cnt`  out  8  saturating framing-error count.

## Operation
- Byte acceptance: `acc = rx_rdy & ~rx_rdy_q`, where `rx_rdy_q` is `rx_rdy` registered. Each byte is accepted exactly once, however long `rx_rdy` is held. `rx_data` is sampled in the `acc` cycle.
- `clr_rx_rdy` is registered and equals `acc` delayed by 1.
- States:
  - HUNT: accepted `HDR` -> HI. Any other byte is dropped silently, with no error.
  - HI: accepted byte -> `hi_r`, go to LO.
  - LO: accepted byte -> `lo_r`, go to CHK.
  - CHK: accepted byte `c`, then -> HUNT.
    - If `c == ~(hi_r + lo_r)`: load `cmd <= {hi_r, lo_r}` and set `cmd_rdy`. The sum is mod 256, 8-bit.
    - Otherwise: pulse `frm_err` and leave `cmd`/`cmd_rdy` unchanged.
- The header value inside HI/LO/CHK is treated as data. There is no resynchronisation on header; only timeout or completion returns to HUNT.
- Timeout:
  - The counter clears on every `acc` and in HUNT, and counts in HI/LO/CHK.
  - When it reaches `TIMEOUT_CYC` with no `acc`: pulse `frm_err`, go to HUNT, discard the partial frame.
  - If `acc` occurs in the same cycle as the terminal count, the byte wins and there is no timeout.
- `cmd_rdy`:
  - Set by a valid frame; cleared by `clr_cmd_rdy`.
  - Set and clear in the same cycle: set wins.
- `overrun`:
  - Set when a valid frame completes while `cmd_rdy`=1 and `clr_cmd_rdy`=0. `cmd` is overwritten.
  - Cleared by `clr_cmd_rdy` unless it is being set in the same cycle.
- `err_cnt`: increments on each `frm_err`, saturates at 255, cleared only by `rst`.

## Timing
- Reset values (all registers, including `rx_rdy_q`):
  - state = HUNT
  - `clr_rx_rdy` = 0, `cmd` = 0, `cmd_rdy` = 0, `frm_err` = 0, `overrun` = 0, `err_cnt` = 0
  - timeout counter = 0
- `rst` mid-frame discards the partial frame; outputs go to their reset values on the next edge.
- All outputs are registered; none is combinational from any input.
- Latency: `cmd`/`cmd_rdy` update on the first edge after the `acc` cycle of the checksum byte (1 clk). `frm_err` has the same latency. `clr_rx_rdy` is high in that same cycle.
- Back-to-back frames: a header accepted in the cycle after CHK completes starts the next frame with no dead cycle.
- Timeout resolution is exact to within 1 clk of `TIMEOUT_CYC`.

## Structure
- Package `uart_cmd_pkg`:
  - state enum `{HUNT, HI, LO, CHK}` (2 bits)
  - `HDR_DEFAULT` constant
  - `function chk8(hi, lo)` returning `~(hi+lo)`
- Sub-module `ibyte_timer`:
  - parameterised by `TIMEOUT_CYC`
  - inputs: `clr`, `en`
  - output: `expired` (one-cycle pulse)
- The FSM, byte edge detect, and the flag and counter logic stay in `uart_cmd_sequencer`.

## Test plan
- Valid frame: bytes A5 12 34 B9 -> `cmd`=16'h1234, `cmd_rdy`=1 one clk after the 4th `acc`; 4 `clr_rx_rdy` pulses; `err_cnt`=0.
- Bad checksum: A5 12 34 B8 -> one `frm_err` pulse; `err_cnt`=1; `cmd_rdy` stays 0; `cmd` unchanged.
- Hunt and header-as-data, run with `TIMEOUT_CYC`=1000: 00 FF A5 A5 A5 B5 -> leading bytes dropped; `cmd`=16'hA5A5, since ~(A5+A5)=~4A=B5. Hold `rx_rdy` high for 5 clks on one byte -> accepted once.
- Timeout, run with `TIMEOUT_CYC`=1000: A5 12, then silence for 1000 clks -> `frm_err` pulse, state HUNT. Then A5 00 01 FE -> `cmd`=16'h0001.
- Overrun and ack race:
  - Two valid frames with no `clr_cmd_rdy` -> `overrun`=1, `cmd` holds the second word.
  - `clr_cmd_rdy` coincident with completion of a third frame -> `cmd_rdy`=1 and `overrun` stays set.
  - A lone `clr_cmd_rdy` afterwards -> `cmd_rdy`=0, `overrun`=0.
- Reset and saturation:
  - `rst` after A5 12 -> all outputs 0; a following frame decodes normally.
  - 300 bad frames -> `err_cnt`=255.
